// File: rtl/cdc_link_arbiter.sv
// cdc_link_arbiter: N requesters share one registered sender link (data/en)
// that feeds CDC receivers. After each transfer the link idles for a
// programmable number of cycles. The arbitration policy is chosen at build
// time: define CDC_LINK_ARBITER_ROUND_ROBIN_EN for round-robin, otherwise
// fixed priority (lowest index wins).
module cdc_link_arbiter #(
  parameter int N = 4,
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] req_data,
  input  logic [7:0]     gap,
  output logic [N-1:0]   ack,
  output logic [W-1:0]   data,
  output logic           en,
  output logic           busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t         state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [N-1:0]   ack_q, ack_d;
  logic [W-1:0]   data_q, data_d;
  logic           en_q, en_d;

  logic [N-1:0]   elig;
  logic [PW-1:0]  win;
  logic           found;
  logic           arb;

`ifdef CDC_LINK_ARBITER_ROUND_ROBIN_EN
  logic [PW-1:0]  ptr_q, ptr_d;

  // Round-robin pick: first eligible requester at or after (last winner + 1).
  always_comb begin
    elig  = req & ~ack_q;
    found = |elig;
    win   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (elig[(int'(ptr_q) + 1 + k) % N]) win = PW'((int'(ptr_q) + 1 + k) % N);
    end
  end
`else
  // Fixed-priority pick: lowest eligible index.
  always_comb begin
    elig  = req & ~ack_q;
    found = |elig;
    win   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (elig[i]) win = PW'(i);
    end
  end
`endif

  // Arbitration happens whenever the link can accept a new transfer next cycle;
  // the gap value is sampled live only while in SEND, so later changes to it
  // cannot disturb a countdown already in progress.
  assign arb = (state_q == IDLE) ||
               ((state_q == SEND) && (gap == 8'd0)) ||
               ((state_q == GAP) && (cnt_q <= 8'd1));

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    en_d    = 1'b0;
    ack_d   = '0;
`ifdef CDC_LINK_ARBITER_ROUND_ROBIN_EN
    ptr_d   = ptr_q;
`endif
    if (arb) begin
      if (found) begin
        state_d    = SEND;
        en_d       = 1'b1;
        data_d     = req_data[int'(win)*W +: W];
        ack_d[win] = 1'b1;
`ifdef CDC_LINK_ARBITER_ROUND_ROBIN_EN
        ptr_d      = win;
`endif
      end else begin
        state_d = IDLE;
      end
    end else if (state_q == SEND) begin
      state_d = GAP;
      cnt_d   = gap;
    end else begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      ack_q   <= '0;
      data_q  <= '0;
      en_q    <= 1'b0;
`ifdef CDC_LINK_ARBITER_ROUND_ROBIN_EN
      ptr_q   <= PW'(N - 1);
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      en_q    <= en_d;
`ifdef CDC_LINK_ARBITER_ROUND_ROBIN_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign ack  = ack_q;
  assign data = data_q;
  assign en   = en_q;
  assign busy = (state_q != IDLE);

endmodule
